// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolutional-coding transmit path: preamble, PN payload
// and zero tail presented bit-serially over valid/ready, with gated PN advance.
module conv_frame_ctrl #(
    parameter int          PRE_LEN   = 8,
    parameter logic [31:0] PRE_PAT   = 32'h0000_00A5,
    parameter int          FRAME_LEN = 64,
    parameter int          TAIL_LEN  = 2,
    parameter int          GAP_LEN   = 4
) (
    input  logic        clk_sig,
    input  logic        rst_sig,
    input  logic        start_sig,
    input  logic        cont_sig,
    input  logic        m_sig,
    output logic        m_en_sig,
    output logic        bit_sig,
    output logic        valid_sig,
    input  logic        ready_sig,
    output logic        sof_sig,
    output logic        tail_sig,
    output logic        eof_sig,
    output logic        busy_sig,
    output logic        done_sig,
    output logic [15:0] frame_cnt_sig
);

    localparam int M1   = (PRE_LEN > FRAME_LEN) ? PRE_LEN : FRAME_LEN;
    localparam int MAXL = (M1 > TAIL_LEN) ? M1 : TAIL_LEN;
    localparam int CW   = $clog2(MAXL) + 1;

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
    localparam logic [7:0]    GAP_END   = 8'(GAP_LEN);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_TAIL, S_GAP} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [7:0]     r_gap;
    logic           r_bit, r_valid, r_sof, r_tail, r_eof, r_busy, r_done;
    logic [15:0]    r_fcnt;

    state_t         w_nstate;
    logic [CW-1:0]  w_ncnt, w_pidx;
    logic [4:0]     w_pbit;
    logic           w_load, w_gap_end, w_start;
    logic           w_beat, w_bit, w_sof, w_tail, w_eof;

    // A frame start loads its first preamble beat on the same edge, whether it
    // comes from IDLE or from the GAP decision cycle in continuous mode.
    always_comb begin
        w_load    = !r_valid || ready_sig;
        w_gap_end = (r_state == S_GAP) && !r_valid && (r_gap == GAP_END);
        w_start   = ((r_state == S_IDLE) && start_sig) || (w_gap_end && cont_sig);
        w_nstate  = r_state;
        w_ncnt    = r_cnt;
        w_beat    = 1'b0;
        w_bit     = 1'b0;
        w_sof     = 1'b0;
        w_tail    = 1'b0;
        w_eof     = 1'b0;
        w_pidx    = w_start ? '0 : r_cnt;
        w_pbit    = 5'(PRE_LEN - 1 - int'(w_pidx));
        if (w_load) begin
            if (w_start || (r_state == S_PRE)) begin
                w_beat = 1'b1;
                w_bit  = PRE_PAT[w_pbit];
                w_sof  = (w_pidx == '0);
                if (w_pidx == PRE_LAST) begin
                    w_nstate = S_DATA;
                    w_ncnt   = '0;
                end else begin
                    w_nstate = S_PRE;
                    w_ncnt   = w_pidx + CW'(1);
                end
            end else if (r_state == S_DATA) begin
                w_beat = 1'b1;
                w_bit  = m_sig;
                if (r_cnt == DATA_LAST) begin
                    w_ncnt = '0;
                    if (TAIL_LEN == 0) begin
                        w_eof    = 1'b1;
                        w_nstate = S_GAP;
                    end else begin
                        w_nstate = S_TAIL;
                    end
                end else begin
                    w_ncnt = r_cnt + CW'(1);
                end
            end else if (r_state == S_TAIL) begin
                w_beat = 1'b1;
                w_tail = 1'b1;
                if (r_cnt == TAIL_LAST) begin
                    w_eof    = 1'b1;
                    w_nstate = S_GAP;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = r_cnt + CW'(1);
                end
            end else if (w_gap_end) begin
                w_nstate = S_IDLE;
            end
        end
    end

    assign m_en_sig = w_load && (r_state == S_DATA);

    always_ff @(posedge clk_sig or negedge rst_sig) begin
        if (!rst_sig) r_state <= S_IDLE;
        else          r_state <= w_nstate;
    end

    always_ff @(posedge clk_sig or negedge rst_sig) begin
        if (!rst_sig) begin
            r_cnt   <= '0;
            r_gap   <= '0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_tail  <= 1'b0;
            r_eof   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            if (w_load) begin
                r_valid <= w_beat;
                r_bit   <= w_bit;
                r_sof   <= w_sof;
                r_tail  <= w_tail;
                r_eof   <= w_eof;
                if (w_beat) r_cnt <= w_ncnt;
            end
            // Gap cycles only count once the eof beat has left the output register.
            if ((r_state == S_GAP) && !r_valid && !w_gap_end) r_gap <= r_gap + 8'd1;
            else                                              r_gap <= '0;
            r_busy <= (w_nstate != S_IDLE);
            r_done <= r_valid && ready_sig && r_eof;
            if (r_valid && ready_sig && r_eof) r_fcnt <= r_fcnt + 16'd1;
        end
    end

    assign bit_sig       = r_bit;
    assign valid_sig     = r_valid;
    assign sof_sig       = r_sof;
    assign tail_sig      = r_tail;
    assign eof_sig       = r_eof;
    assign busy_sig      = r_busy;
    assign done_sig      = r_done;
    assign frame_cnt_sig = r_fcnt;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: two instances (default-like and TAIL=0/GAP=0),
// a PN model per instance, and a beat scoreboard checked on the falling edge.
module tb_conv_frame_ctrl;

    typedef struct packed { logic b; logic sof; logic tail; logic eof; } beat_t;
    typedef struct { int d; int pct; int cont; int nfr; int exp_fcnt; int exp_men; int exp_gap; int mid; } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  start, cont, m, men, bitv, valid, ready, sof, tail, eof, busy, done;
    logic [15:0] fcnt [2];
    logic [6:0]  pn [2] = '{7'h5A, 7'h33};
    logic [6:0]  rf [2] = '{7'h5A, 7'h33};
    int          pct [2] = '{100, 100};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    beat_t       exp_q [2][$];
    int          men_cnt [2], sof_cnt [2], last_sof [2], gap_min [2], gap_max [2];
    int          done_cyc [2], bf_cyc [2];
    logic [15:0] acc_eof [2];
    logic        exp_done [2], prev_stall [2], prev_busy [2];
    beat_t       prev_beat [2];

    conv_frame_ctrl #(.PRE_LEN(8), .PRE_PAT(32'h0000_00A5), .FRAME_LEN(16), .TAIL_LEN(2), .GAP_LEN(4)) u0 (
        .clk_sig(clk), .rst_sig(rst_n), .start_sig(start[0]), .cont_sig(cont[0]), .m_sig(m[0]),
        .m_en_sig(men[0]), .bit_sig(bitv[0]), .valid_sig(valid[0]), .ready_sig(ready[0]),
        .sof_sig(sof[0]), .tail_sig(tail[0]), .eof_sig(eof[0]), .busy_sig(busy[0]),
        .done_sig(done[0]), .frame_cnt_sig(fcnt[0]));

    conv_frame_ctrl #(.PRE_LEN(4), .PRE_PAT(32'h0000_0009), .FRAME_LEN(8), .TAIL_LEN(0), .GAP_LEN(0)) u1 (
        .clk_sig(clk), .rst_sig(rst_n), .start_sig(start[1]), .cont_sig(cont[1]), .m_sig(m[1]),
        .m_en_sig(men[1]), .bit_sig(bitv[1]), .valid_sig(valid[1]), .ready_sig(ready[1]),
        .sof_sig(sof[1]), .tail_sig(tail[1]), .eof_sig(eof[1]), .busy_sig(busy[1]),
        .done_sig(done[1]), .frame_cnt_sig(fcnt[1]));

    function automatic int pl(input int d); return (d == 0) ? 8 : 4;  endfunction
    function automatic int fl(input int d); return (d == 0) ? 16 : 8; endfunction
    function automatic int tl(input int d); return (d == 0) ? 2 : 0;  endfunction
    function automatic int gl(input int d); return (d == 0) ? 4 : 0;  endfunction
    function automatic logic [6:0] lfsr_step(input logic [6:0] s); return {s[5:0], s[6] ^ s[5]}; endfunction

    // PN source: advances only when the DUT consumes a bit
    assign m[0] = pn[0][6];
    assign m[1] = pn[1][6];
    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (men[d]) pn[d] <= lfsr_step(pn[d]);

    initial begin
        ready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                ready[d] = (pct[d] >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct[d]);
        end
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        beat_t cur, e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                exp_done[d] = 1'b0; prev_stall[d] = 1'b0; prev_busy[d] = 1'b0; acc_eof[d] = '0;
            end else begin
                cur = '{bitv[d], sof[d], tail[d], eof[d]};
                check(done[d] == exp_done[d], "done_pulse", int'(done[d]), int'(exp_done[d]));
                check(fcnt[d] == acc_eof[d], "frame_cnt", int'(fcnt[d]), int'(acc_eof[d]));
                exp_done[d] = 1'b0;
                if (prev_stall[d])
                    check(valid[d] && (cur == prev_beat[d]), "stall_hold", int'(cur), int'(prev_beat[d]));
                if (valid[d] && !ready[d])
                    check(men[d] == 1'b0, "stall_m_en", int'(men[d]), 0);
                prev_stall[d] = valid[d] && !ready[d];
                prev_beat[d]  = cur;
                if (men[d]) men_cnt[d]++;
                if (valid[d] && ready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check(1'b0, "extra_beat", int'(cur), 0);
                    end else begin
                        e = exp_q[d].pop_front();
                        check(cur == e, "beat", int'(cur), int'(e));
                    end
                    if (sof[d]) begin
                        sof_cnt[d]++;
                        if (last_sof[d] >= 0) begin
                            if (cyc - last_sof[d] < gap_min[d]) gap_min[d] = cyc - last_sof[d];
                            if (cyc - last_sof[d] > gap_max[d]) gap_max[d] = cyc - last_sof[d];
                        end
                        last_sof[d] = cyc;
                    end
                    if (eof[d]) begin
                        exp_done[d] = 1'b1;
                        acc_eof[d]  = acc_eof[d] + 16'd1;
                    end
                end
                if (done[d]) done_cyc[d] = cyc;
                if (prev_busy[d] && !busy[d]) bf_cyc[d] = cyc;
                prev_busy[d] = busy[d];
            end
        end
    end

    task automatic push_frame(input int d);
        beat_t       b;
        logic [31:0] pat;
        pat = (d == 0) ? 32'h0000_00A5 : 32'h0000_0009;
        for (int i = pl(d) - 1; i >= 0; i--) begin
            b = '{pat[i], (i == pl(d) - 1), 1'b0, 1'b0};
            exp_q[d].push_back(b);
        end
        for (int i = 0; i < fl(d); i++) begin
            b = '{rf[d][6], 1'b0, 1'b0, (tl(d) == 0) && (i == fl(d) - 1)};
            rf[d] = lfsr_step(rf[d]);
            exp_q[d].push_back(b);
        end
        for (int i = 0; i < tl(d); i++) begin
            b = '{1'b0, 1'b0, 1'b1, (i == tl(d) - 1)};
            exp_q[d].push_back(b);
        end
    endtask

    task automatic clear_stats(input int d);
        men_cnt[d] = 0; sof_cnt[d] = 0; last_sof[d] = -1;
        gap_min[d] = 1 << 30; gap_max[d] = 0; done_cyc[d] = -1; bf_cyc[d] = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check((bitv | valid | sof | tail | eof | busy | done | men) == 2'b00 && fcnt[0] == 16'd0 && fcnt[1] == 16'd0,
              "reset_outputs", int'({bitv, valid, sof, tail, eof, busy, done, men}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input string name);
        int n;
        n = 0;
        while (!(!busy[d] && exp_q[d].size() == 0) && n < 3000) begin
            @(negedge clk); n++;
        end
        check(n < 3000, name, n, 3000);
        repeat (8) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int d, n;
        d = v.d;
        do_reset();
        pct[d]  = v.pct;
        cont[d] = (v.cont != 0);
        clear_stats(d);
        for (int f = 0; f < v.nfr; f++) push_frame(d);
        pulse_start(d);
        check(valid[d] && sof[d] && busy[d] && bitv[d], "start_latency", int'({valid[d], sof[d], busy[d], bitv[d]}), 15);
        if (v.mid != 0) begin
            n = 0;
            while (men_cnt[d] < 4 && n < 500) begin @(negedge clk); n++; end
            check(n < 500, "wait_mid_data", n, 500);
            pulse_start(d);
        end
        if (v.cont != 0) begin
            n = 0;
            while (sof_cnt[d] < v.nfr && n < 3000) begin @(negedge clk); n++; end
            check(n < 3000, "wait_last_sof", n, 3000);
            cont[d] = 1'b0;
        end
        wait_idle(d, "wait_idle");
        check(int'(fcnt[d]) == v.exp_fcnt, "frame_cnt_final", int'(fcnt[d]), v.exp_fcnt);
        check(men_cnt[d] == v.exp_men, "m_en_count", men_cnt[d], v.exp_men);
        check(bf_cyc[d] - done_cyc[d] == gl(d) + 1, "busy_fall_after_done", bf_cyc[d] - done_cyc[d], gl(d) + 1);
        if (v.exp_gap != 0) begin
            check(gap_min[d] == v.exp_gap, "sof_spacing_min", gap_min[d], v.exp_gap);
            check(gap_max[d] == v.exp_gap, "sof_spacing_max", gap_max[d], v.exp_gap);
        end
        pct[d]  = 100;
        cont[d] = 1'b0;
    endtask

    initial begin
        vec_t tv [7];
        int   n;
        //       d  pct cont nfr fcnt men gap mid
        tv[0] = '{0, 100, 0,  1,  1,  16,  0, 0};
        tv[1] = '{0,  50, 0,  1,  1,  16,  0, 0};
        tv[2] = '{0, 100, 1,  3,  3,  48, 31, 0};
        tv[3] = '{0, 100, 0,  1,  1,  16,  0, 1};
        tv[4] = '{1, 100, 0,  1,  1,   8,  0, 0};
        tv[5] = '{1, 100, 1,  3,  3,  24, 13, 0};
        tv[6] = '{1,  50, 1,  2,  2,  16,  0, 0};
        rst_n = 1'b1;
        start = 2'b00;
        cont  = 2'b00;
        #3;
        for (int i = 0; i < 7; i++) run_vec(tv[i]);

        // Asynchronous reset during the tail, then a clean frame afterwards
        do_reset();
        clear_stats(0);
        push_frame(0);
        pulse_start(0);
        n = 0;
        while (!(valid[0] && tail[0]) && n < 200) begin @(negedge clk); n++; end
        check(n < 200, "wait_tail", n, 200);
        #2 rst_n = 1'b0;
        #1;
        check({bitv[0], valid[0], sof[0], tail[0], eof[0], busy[0], done[0], men[0]} == 8'd0 && fcnt[0] == 16'd0,
              "reset_async_mid_frame", int'({bitv[0], valid[0], sof[0], tail[0], eof[0], busy[0], done[0], men[0]}), 0);
        exp_q[0].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats(0);
        push_frame(0);
        pulse_start(0);
        check(valid[0] && sof[0] && busy[0], "restart_sof", int'({valid[0], sof[0], busy[0]}), 7);
        wait_idle(0, "wait_idle_after_reset");
        check(fcnt[0] == 16'd1, "frame_cnt_after_reset", int'(fcnt[0]), 1);
        check(men_cnt[0] == 16, "m_en_after_reset", men_cnt[0], 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
